// File: rtl/accum.sv
// Streaming accumulator: sums a dti transaction of operands up to eot and emits one sum.
// Optional ACCUM_SATURATE_EN makes each addition saturate instead of wrapping mod 2^DOUT.
module accum #(
  parameter int DIN        = 16,
  parameter int DOUT       = 32,
  parameter bit DIN_SIGNED = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [DIN:0]    din_data,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [DOUT-1:0] dout_data
);

  if (DOUT < DIN) begin : g_width_check
    $error("accum: DOUT must be >= DIN");
  end

  typedef enum logic {ACC, OUT} state_t;

  state_t            state_q, state_d;
  logic [DOUT-1:0]   acc_q, acc_d;
  logic              first_q, first_d;
  // Low through reset, high from the first edge after release; gates din_ready.
  logic              live_q;
  logic [DOUT-1:0]   op_ext;
  logic [DOUT-1:0]   sum;
  logic              eot;

  assign eot = din_data[DIN];

  always_comb begin
    if (DIN_SIGNED) op_ext = DOUT'($signed(din_data[DIN-1:0]));
    else            op_ext = DOUT'(din_data[DIN-1:0]);
  end

`ifdef ACCUM_SATURATE_EN
  localparam logic [DOUT-1:0] SMIN = {1'b1, {(DOUT-1){1'b0}}};
  localparam logic [DOUT-1:0] SMAX = {1'b0, {(DOUT-1){1'b1}}};
  logic [DOUT:0]   wide;
  logic [DOUT-1:0] raw;
  logic            ovf;

  always_comb begin
    wide = {1'b0, acc_q} + {1'b0, op_ext};
    raw  = wide[DOUT-1:0];
    // Signed overflow: both addends share a sign the result does not.
    ovf  = (acc_q[DOUT-1] == op_ext[DOUT-1]) && (raw[DOUT-1] != acc_q[DOUT-1]);
    if (DIN_SIGNED) sum = ovf ? (acc_q[DOUT-1] ? SMIN : SMAX) : raw;
    else            sum = wide[DOUT] ? '1 : raw;
  end
`else
  assign sum = acc_q + op_ext;
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    first_d    = first_q;
    din_ready  = live_q && (state_q == ACC);
    dout_valid = (state_q == OUT);
    dout_data  = acc_q;
    case (state_q)
      ACC: begin
        if (din_valid && din_ready) begin
          acc_d   = first_q ? op_ext : sum;
          first_d = 1'b0;
          if (eot) begin
            state_d = OUT;
            first_d = 1'b1;
          end
        end
      end
      OUT: begin
        if (dout_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      first_q <= 1'b1;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      first_q <= first_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_accum.sv
// Four accum instances (u16, s16, u8, s8; all DIN=8) share one stimulus stream;
// a scoreboard checks every delivered sum against an arithmetic reference model.
module tb_accum;
  logic        clk = 1'b0;
  logic        rst_n, din_valid, dout_ready;
  logic [8:0]  din_data;
  logic [3:0]  dinr, dv;
  logic [15:0] d16u, d16s;
  logic [7:0]  d8u, d8s;
  int          tests = 0, fails = 0;
  int          rdy_mode = 0;

`ifdef ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef logic [3:0][15:0] exp_t;
  exp_t q[$];
  exp_t m;
  bit   first = 1'b1;

  always #5 clk = ~clk;

  accum #(.DIN(8), .DOUT(16), .DIN_SIGNED(1'b0)) u_u16 (.clk(clk), .rst(rst_n),
    .din_valid(din_valid), .din_ready(dinr[0]), .din_data(din_data),
    .dout_valid(dv[0]), .dout_ready(dout_ready), .dout_data(d16u));
  accum #(.DIN(8), .DOUT(16), .DIN_SIGNED(1'b1)) u_s16 (.clk(clk), .rst(rst_n),
    .din_valid(din_valid), .din_ready(dinr[1]), .din_data(din_data),
    .dout_valid(dv[1]), .dout_ready(dout_ready), .dout_data(d16s));
  accum #(.DIN(8), .DOUT(8), .DIN_SIGNED(1'b0)) u_u8 (.clk(clk), .rst(rst_n),
    .din_valid(din_valid), .din_ready(dinr[2]), .din_data(din_data),
    .dout_valid(dv[2]), .dout_ready(dout_ready), .dout_data(d8u));
  accum #(.DIN(8), .DOUT(8), .DIN_SIGNED(1'b1)) u_s8 (.clk(clk), .rst(rst_n),
    .din_valid(din_valid), .din_ready(dinr[3]), .din_data(din_data),
    .dout_valid(dv[3]), .dout_ready(dout_ready), .dout_data(d8s));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Running sum as a mathematical integer, then wrapped or clamped to w bits.
  function automatic logic [15:0] step(input logic [15:0] acc, input logic [7:0] op,
                                       input bit fst, input int w, input bit sg);
    longint mask, a, o, s, hi, lo;
    mask = (longint'(1) << w) - 1;
    a = longint'(acc) & mask;
    if (sg) begin
      o = longint'($signed(op));
      if (a >= (longint'(1) << (w - 1))) a = a - (longint'(1) << w);
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -(longint'(1) << (w - 1));
    end else begin
      o  = longint'(op);
      hi = mask;
      lo = 0;
    end
    if (fst) a = 0;
    s = a + o;
    if (SAT) begin
      if (s > hi) s = hi;
      if (s < lo) s = lo;
    end
    return 16'(s & mask);
  endfunction

  task automatic mreset();
    first = 1'b1;
    q.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] op, input bit eot, output int cyc);
    bit acc;
    cyc = 0;
    din_valid = 1'b1;
    din_data  = {eot, op};
    do begin
      @(negedge clk);
      acc = dinr[0];
      @(posedge clk);
      cyc++;
    end while (!acc && cyc < 200);
    #1;
    din_valid = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL din_timeout: op 0x%0h not accepted in %0d cycles", op, cyc);
    end else begin
      for (int i = 0; i < 4; i++) m[i] = step(m[i], op, first, (i < 2) ? 16 : 8, i[0]);
      first = 1'b0;
      if (eot) begin
        q.push_back(m);
        first = 1'b1;
      end
    end
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = ($urandom % 4) != 0;
      default: dout_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && dv != 4'h0) begin
      chk("valid_agree", {28'h0, dv}, 32'hF);
      if (dout_ready) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out: got 0x%0h with no result pending", d16u);
        end else begin
          e = q.pop_front();
          chk("sb_u16", {16'h0, d16u}, {16'h0, e[0]});
          chk("sb_s16", {16'h0, d16s}, {16'h0, e[1]});
          chk("sb_u8",  {24'h0, d8u},  {16'h0, e[2]});
          chk("sb_s8",  {24'h0, d8s},  {16'h0, e[3]});
        end
      end
    end
  end

  initial begin
    int c, n, len;
    logic [7:0] op;
    rst_n = 1'b0; din_valid = 1'b0; din_data = '0; dout_ready = 1'b1;
    #3;
    chk("rst_valid", {28'h0, dv}, 32'h0);
    chk("rst_ready", {28'h0, dinr}, 32'h0);
    chk("rst_data", {d16u, d16s}, 32'h0);
    chk("rst_data8", {16'h0, d8u, d8s}, 32'h0);
    #19 rst_n = 1'b1;
    #2 chk("ready_pre_edge", {28'h0, dinr}, 32'h0);
    @(negedge clk);
    chk("ready_after_rst", {28'h0, dinr}, 32'hF);
    realign();

    send(8'd10, 1'b0, c);
    send(8'd20, 1'b0, c);
    chk("stream_rate", c, 1);
    send(8'd30, 1'b1, c);
    @(negedge clk);
    chk("latency_valid", {31'h0, dv[0]}, 32'h1);
    chk("sum_60", {16'h0, d16u}, 32'd60);
    realign();
    @(negedge clk);
    chk("ready_after_hs", {28'h0, dinr}, 32'hF);
    realign();

    send(8'h7F, 1'b1, c);
    @(negedge clk);
    chk("single_7f", {16'h0, d16u}, 32'h7F);
    realign();
    send(8'd1, 1'b0, c);
    chk("b2b_accept", c, 1);
    send(8'd2, 1'b1, c);
    @(negedge clk);
    chk("b2b_sum3", {16'h0, d16u}, 32'd3);
    realign();

    send(8'hFD, 1'b0, c);
    send(8'h05, 1'b0, c);
    send(8'hF9, 1'b1, c);
    @(negedge clk);
    chk("signed_m5", {16'h0, d16s}, 32'hFFFB);
    realign();

    send(8'd200, 1'b0, c);
    send(8'd100, 1'b1, c);
    @(negedge clk);
    chk("ovf_u8", {24'h0, d8u}, SAT ? 32'd255 : 32'd44);
    realign();
    send(8'd127, 1'b0, c);
    send(8'd1, 1'b1, c);
    @(negedge clk);
    chk("ovf_s8", {24'h0, d8s}, SAT ? 32'h7F : 32'h80);
    realign();

    rdy_mode = 2;
    send(8'd7, 1'b0, c);
    send(8'd8, 1'b1, c);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", {31'h0, dv[0]}, 32'h1);
      chk("bp_data", {16'h0, d16u}, 32'd15);
      chk("bp_stall", {28'h0, dinr}, 32'h0);
    end
    realign();
    rdy_mode = 0;
    realign();
    @(negedge clk);
    chk("bp_once", {28'h0, dv}, 32'h0);
    realign();

    send(8'd5, 1'b0, c);
    send(8'd6, 1'b0, c);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {28'h0, dv}, 32'h0);
    chk("midrst_ready", {28'h0, dinr}, 32'h0);
    mreset();
    realign();
    chk("rst_hold_ready", {28'h0, dinr}, 32'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_wait_edge", {28'h0, dinr}, 32'h0);
    @(negedge clk);
    chk("rel_ready", {28'h0, dinr}, 32'hF);
    realign();
    send(8'd4, 1'b1, c);
    @(negedge clk);
    chk("post_rst_sum4", {16'h0, d16u}, 32'd4);
    realign();

    rdy_mode = 2;
    send(8'd9, 1'b1, c);
    @(negedge clk);
    chk("out_valid", {31'h0, dv[0]}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("outrst_valid", {28'h0, dv}, 32'h0);
    chk("outrst_data", {d16u, d16s}, 32'h0);
    mreset();
    realign();
    rdy_mode = 0;
    #2 rst_n = 1'b1;
    realign();

    rdy_mode = 1;
    repeat (40) begin
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        case ($urandom % 8)
          0:       op = 8'hFF;
          1:       op = 8'h80;
          2:       op = 8'h7F;
          default: op = 8'($urandom);
        endcase
        if ($urandom % 3 == 0) realign();
        send(op, k == len - 1, c);
      end
    end
    rdy_mode = 0;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    @(negedge clk);
    @(negedge clk);
    chk("idle_end", {28'h0, dv}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/accum.md
# accum

Streaming accumulator: consumes a transaction of operands on a `dti` queue interface, sums all elements up to and including the one flagged end-of-transaction (eot), and emits one sum per transaction. It is the downstream neighbour of `add` in reduction datapaths, sized so that `add`'s widened result can be fed straight in. `accum` provides per-transaction reduction; `add` is element-wise.

## Interface
Parameters:
- `DIN`, 16: operand width in bits, excluding eot.
- `DOUT`, 32: accumulator and result width. `DOUT >= DIN` is required; violation is an elaboration error.
- `DIN_SIGNED`, 0: 1 means operands and result are two's complement; 0 means unsigned.

Ports:
- `clk`, input, 1: the single clock. All state is on its rising edge.
- `rst`, input, 1: reset, **asynchronous and active-low**.
- `din`, `dti.consumer`, data `DIN+1`: `data[DIN-1:0]` is the operand, `data[DIN]` is eot.
- `dout`, `dti.producer`, data `DOUT`: the transaction sum.

## Operation
- Operands are zero-extended to `DOUT` when `DIN_SIGNED=0` and sign-extended when `DIN_SIGNED=1`.
- State machine with two states:
  - `ACC`: `din.ready=1`, `dout.valid=0`.
    - On a `din` handshake, `acc <= first ? ext(op) : acc + ext(op)`. `first` is cleared.
    - If eot is set, go to `OUT` and set `first`.
  - `OUT`: `din.ready=0`, `dout.valid=1`, `dout.data=acc`.
    - On a `dout` handshake, go to `ACC`.
- Arithmetic wraps modulo 2^`DOUT` by default.
- A one-element transaction (eot on the first element) yields `ext(op)`.
- There is no empty transaction. Every result comes from at least one element.
- `dout.valid` does not depend combinationally on `dout.ready`. `din.ready` depends only on state.
- Reset (`rst` low), including mid-transaction: asynchronously go to `ACC` with `first=1`, `acc=0`, `dout.valid=0`, `dout.data=0`, `din.ready=0`. Partial sums are discarded. `din.ready` rises in the first cycle after `rst` deasserts.

## Timing
- Accepts one element per cycle while in `ACC`.
- Latency: `dout.valid` rises 1 cycle after the eot handshake.
- Every transaction costs at least 1 extra cycle (the `OUT` state), during which `din.ready=0`.
- Under `dout` backpressure, `dout.data` and `dout.valid` stay stable until the handshake. `din` is stalled for the whole period.
- After the `dout` handshake cycle, `din.ready=1` in the next cycle. Back-to-back transactions are therefore N+1 cycles each, for N elements.
- A `din.valid` that is high while in `OUT` is not accepted. `din` must hold it per `dti` rules.

## Configuration
- `ACCUM_SATURATE_EN` defined: each addition saturates instead of wrapping.
  - Unsigned: clamps to 2^`DOUT`-1.
  - Signed: clamps to 2^(`DOUT`-1)-1 or -2^(`DOUT`-1), depending on overflow direction.
  - Saturation is sticky within a transaction only through the value itself; later operands continue from the clamped value.
- `ACCUM_SATURATE_EN` undefined: modulo-2^`DOUT` wrap. There is no saturation logic.

## Test plan
- Unsigned sum, `DIN=8`, `DOUT=16`: operands 10, 20, 30 (eot), sent on consecutive cycles → `dout.data=60` with `dout.valid` 1 cycle after the eot handshake. The next transaction is accepted in the cycle after the `dout` handshake.
- Backpressure: hold `dout.ready=0` for 5 cycles after the result appears → `dout.valid=1` and data stay stable, `din.ready=0` throughout, and exactly one result is delivered.
- Signed, `DIN=8`, `DOUT=16`: operands -3, 5, -7 (eot) → `dout.data=0xFFFB` (-5).
- Overflow, `DIN=8`, `DOUT=8`, unsigned: operands 200, 100 (eot) → 44 without `ACCUM_SATURATE_EN`, 255 with it. Signed case: 127, 1 (eot) → -128 without the macro, 127 with it.
- Single-element and back-to-back transactions: 0x7F (eot), then 1, 2 (eot), with `dout.ready` always 1 → results 0x007F and 3. The second sum does not include the first transaction's value.
- Reset mid-transaction: after 2 accepted elements (5, 6), pulse `rst` low asynchronously (not clock-aligned) → `dout.valid=0` immediately and `din.ready=0` while `rst` is low. A new transaction 4 (eot) then yields 4.
